// File: rtl/parity_accumulator.sv
// Streaming even/odd parity generator/checker: per-lane and whole-frame parity
// accumulated over multi-beat frames, result presented through a valid/ready handshake.
module parity_accumulator #(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             odd_mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_exp_par,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_par,
    output logic [LANES-1:0] out_lane_par,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_err,
    output logic             out_ovf
);
    localparam int LW = WIDTH / LANES;

    typedef enum logic {S_ACC, S_DONE} state_t;

    state_t           state_q;
    logic [LANES-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             first_q;
    logic             mode_q;
    logic             ovf_q;

    logic             par_q;
    logic [LANES-1:0] lane_par_q;
    logic [CNT_W-1:0] beats_q;
    logic             err_q;
    logic             ovf_out_q;

    logic [LANES-1:0] lane_x;
    logic [LANES-1:0] acc_d;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_d;
    logic             mode_eff;
    logic             par_d;
    logic             accept;

    assign in_ready  = (state_q == S_ACC);
    assign out_valid = (state_q == S_DONE);

    always_comb begin
        lane_x = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_x[i] = ^in_data[i*LW +: LW];
        end
    end

    // Next-state values for an accepted beat; the counter saturates at all-ones.
    always_comb begin
        accept   = in_valid && (state_q == S_ACC);
        acc_d    = acc_q ^ lane_x;
        mode_eff = first_q ? odd_mode : mode_q;
        cnt_d    = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        ovf_d    = ovf_q | (&cnt_q);
        par_d    = (^acc_d) ^ mode_eff;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_ACC;
            acc_q      <= '0;
            cnt_q      <= '0;
            first_q    <= 1'b1;
            mode_q     <= 1'b0;
            ovf_q      <= 1'b0;
            par_q      <= 1'b0;
            lane_par_q <= '0;
            beats_q    <= '0;
            err_q      <= 1'b0;
            ovf_out_q  <= 1'b0;
        end else begin
            case (state_q)
                S_ACC: begin
                    if (accept) begin
                        acc_q   <= acc_d;
                        cnt_q   <= cnt_d;
                        ovf_q   <= ovf_d;
                        first_q <= 1'b0;
                        if (first_q) mode_q <= odd_mode;
                        if (in_last) begin
                            par_q      <= par_d;
                            lane_par_q <= acc_d ^ {LANES{mode_eff}};
                            beats_q    <= cnt_d;
                            err_q      <= par_d != in_exp_par;
                            ovf_out_q  <= ovf_d;
                            state_q    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // Result registers keep their value; only the accumulation state is cleared.
                    if (out_ready) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        first_q <= 1'b1;
                        state_q <= S_ACC;
                    end
                end
                default: state_q <= S_ACC;
            endcase
        end
    end

    assign out_par      = par_q;
    assign out_lane_par = lane_par_q;
    assign out_beats    = beats_q;
    assign out_err      = err_q;
    assign out_ovf      = ovf_out_q;
endmodule

// File: tb/tb_parity_accumulator.sv
// Self-checking bench for parity_accumulator: directed scenarios plus randomized
// frames compared against a bit-counting reference model.
module tb_parity_accumulator;
    localparam int WIDTH = 32;
    localparam int LANES = 4;
    localparam int CNT_W = 8;
    localparam int LW    = WIDTH / LANES;
    localparam int RW    = 1 + LANES + CNT_W + 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             odd_mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             in_exp_par;
    logic             out_valid;
    logic             out_ready;
    logic             out_par;
    logic [LANES-1:0] out_lane_par;
    logic [CNT_W-1:0] out_beats;
    logic             out_err;
    logic             out_ovf;

    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] beats_q[$];

    parity_accumulator #(.WIDTH(WIDTH), .LANES(LANES), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .odd_mode(odd_mode), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .in_exp_par(in_exp_par), .out_valid(out_valid), .out_ready(out_ready),
        .out_par(out_par), .out_lane_par(out_lane_par), .out_beats(out_beats),
        .out_err(out_err), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [RW-1:0] observed();
        return {out_par, out_lane_par, out_beats, out_err, out_ovf};
    endfunction

    // Reference: parity is the count of ones modulo 2, inverted in odd mode.
    function automatic logic [RW-1:0] model(input bit mode, input bit exp);
        int lane_ones[LANES];
        int total;
        int n;
        logic [LANES-1:0] lp;
        logic [CNT_W-1:0] nb;
        logic par;
        total = 0;
        for (int i = 0; i < LANES; i++) lane_ones[i] = 0;
        foreach (beats_q[k]) begin
            for (int i = 0; i < LANES; i++) begin
                lane_ones[i] += $countones((beats_q[k] >> (i*LW)) & ((1 << LW) - 1));
            end
            total += $countones(beats_q[k]);
        end
        for (int i = 0; i < LANES; i++) lp[i] = ((lane_ones[i] % 2) == 1) ^ mode;
        par = ((total % 2) == 1) ^ mode;
        n = beats_q.size();
        nb = (n > (1 << CNT_W) - 1) ? CNT_W'((1 << CNT_W) - 1) : CNT_W'(n);
        return {par, lp, nb, par != exp, n > (1 << CNT_W) - 1};
    endfunction

    // Drives beats_q as one frame; later beats carry random odd_mode/exp noise.
    task automatic drive_frame(input bit mode, input bit exp, input int gap_pct);
        int n;
        n = beats_q.size();
        for (int k = 0; k < n; k++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                in_last  = 1'($urandom);
                @(negedge clk);
            end
            in_valid   = 1'b1;
            in_data    = beats_q[k];
            in_last    = (k == n - 1);
            odd_mode   = (k == 0) ? mode : 1'($urandom);
            in_exp_par = (k == n - 1) ? exp : 1'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; odd_mode = 1'b0;
        in_data = '0; in_last = 1'b0; in_exp_par = 1'b0;
        #3;
        checks++;
        if ({in_ready, out_valid} !== 2'b10 || observed() !== '0)
            begin errors++; $display("FAIL reset_state: rdy/vld=%b res=%h want 10/0", {in_ready, out_valid}, observed()); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b10 || observed() !== '0)
            begin errors++; $display("FAIL post_reset: rdy/vld=%b res=%h want 10/0", {in_ready, out_valid}, observed()); end
    endtask

    task automatic test_single();
        beats_q = {32'h0000_00BC};
        drive_frame(1'b0, 1'b1, 0);
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0)
            begin errors++; $display("FAIL single_latency: vld=%b rdy=%b want 1 0", out_valid, in_ready); end
        checks++;
        if (observed() !== {1'b1, 4'b0001, 8'd1, 1'b0, 1'b0})
            begin errors++; $display("FAIL single_even: got %h want %h", observed(), {1'b1, 4'b0001, 8'd1, 1'b0, 1'b0}); end
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL single_consume: vld=%b rdy=%b want 0 1", out_valid, in_ready); end
        drive_frame(1'b1, 1'b1, 0);
        checks++;
        if (out_valid !== 1'b1 || observed() !== {1'b0, 4'b1110, 8'd1, 1'b1, 1'b0})
            begin errors++; $display("FAIL single_odd: vld=%b got %h want %h", out_valid, observed(), {1'b0, 4'b1110, 8'd1, 1'b1, 1'b0}); end
        consume();
    endtask

    task automatic test_back_to_back();
        beats_q = {32'h0000_00FF, 32'h0000_0001, 32'h8000_0000};
        drive_frame(1'b0, 1'b0, 0);
        checks++;
        if (out_valid !== 1'b1 || observed() !== {1'b0, 4'b1001, 8'd3, 1'b0, 1'b0})
            begin errors++; $display("FAIL three_beat: vld=%b got %h want %h", out_valid, observed(), {1'b0, 4'b1001, 8'd3, 1'b0, 1'b0}); end
        consume();
    endtask

    task automatic test_backpressure();
        logic [RW-1:0] exp_r;
        beats_q = {32'h1234_5678, 32'hDEAD_BEEF};
        exp_r = model(1'b1, 1'b0);
        drive_frame(1'b1, 1'b0, 0);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_last  = 1'b1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || observed() !== exp_r)
                begin errors++; $display("FAIL backpressure c%0d: rdy=%b vld=%b got %h want %h", c, in_ready, out_valid, observed(), exp_r); end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL bp_release: vld=%b rdy=%b want 0 1", out_valid, in_ready); end
        beats_q = {32'h0000_0003};
        exp_r = model(1'b0, 1'b1);
        drive_frame(1'b0, 1'b1, 0);
        checks++;
        if (out_valid !== 1'b1 || observed() !== exp_r)
            begin errors++; $display("FAIL bp_next_frame: vld=%b got %h want %h", out_valid, observed(), exp_r); end
        consume();
    endtask

    task automatic test_overflow();
        beats_q = {};
        for (int k = 0; k < 300; k++) beats_q.push_back(32'h0000_0001);
        drive_frame(1'b0, 1'b0, 0);
        checks++;
        if (out_valid !== 1'b1 || observed() !== {1'b0, 4'b0000, 8'd255, 1'b0, 1'b1})
            begin errors++; $display("FAIL overflow: vld=%b got %h want %h", out_valid, observed(), {1'b0, 4'b0000, 8'd255, 1'b0, 1'b1}); end
        consume();
        beats_q = {32'h0000_0100};
        drive_frame(1'b0, 1'b0, 0);
        checks++;
        if (out_valid !== 1'b1 || observed() !== {1'b1, 4'b0010, 8'd1, 1'b1, 1'b0})
            begin errors++; $display("FAIL ovf_cleared: vld=%b got %h want %h", out_valid, observed(), {1'b1, 4'b0010, 8'd1, 1'b1, 1'b0}); end
        consume();
    endtask

    task automatic test_reset_midframe();
        in_valid = 1'b1; in_last = 1'b0; odd_mode = 1'b1;
        in_data = 32'h0F0F_0001;
        @(negedge clk);
        in_data = 32'h0000_0107;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10 || observed() !== '0)
            begin errors++; $display("FAIL reset_midframe: rdy/vld=%b res=%h want 10/0", {in_ready, out_valid}, observed()); end
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        beats_q = {32'h0000_00BC};
        drive_frame(1'b0, 1'b1, 0);
        checks++;
        if (out_valid !== 1'b1 || observed() !== {1'b1, 4'b0001, 8'd1, 1'b0, 1'b0})
            begin errors++; $display("FAIL after_reset_frame: vld=%b got %h want %h", out_valid, observed(), {1'b1, 4'b0001, 8'd1, 1'b0, 1'b0}); end
        consume();
    endtask

    task automatic test_random();
        logic [RW-1:0] exp_r;
        bit mode, exp, ok;
        int n;
        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(12, 1);
            beats_q = {};
            for (int k = 0; k < n; k++) beats_q.push_back($urandom);
            mode = 1'($urandom);
            exp  = 1'($urandom);
            exp_r = model(mode, exp);
            drive_frame(mode, exp, 30);
            ok = 1'b0;
            for (int c = 0; c < 20; c++) begin
                if (out_valid === 1'b1) begin ok = 1'b1; break; end
                @(negedge clk);
            end
            checks++;
            if (!ok || observed() !== exp_r)
                begin errors++; $display("FAIL random f%0d n%0d: vld=%b got %h want %h", f, n, out_valid, observed(), exp_r); end
            repeat ($urandom_range(3)) @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || observed() !== exp_r)
                begin errors++; $display("FAIL random_hold f%0d: vld=%b got %h want %h", f, out_valid, observed(), exp_r); end
            consume();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/parity_accumulator.md
# parity_accumulator

Streaming, parametrised parity generator/checker for the P7 datapath. It accumulates even or odd parity over a multi-beat frame, both per byte-lane and over the whole frame. It compares the frame parity against an expected value and presents the result through a valid/ready output handshake. It generalises single-word reduction-XOR parity to configurable width, lane count, parity mode and multi-beat framing.

## Interface
Parameters:
- `WIDTH`, 32: data beat width in bits; must be a multiple of `LANES`.
- `LANES`, 4: number of equal lane slices; lane i is `in_data[(i+1)*WIDTH/LANES-1 : i*WIDTH/LANES]`.
- `CNT_W`, 8: beat-counter width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; low clears all state immediately.
- `odd_mode`  in  1  parity mode, sampled on the first accepted beat of a frame: 0 = even, 1 = odd.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_data`  in  WIDTH  beat payload.
- `in_last`  in  1  marks the final beat of the frame.
- `in_exp_par`  in  1  expected frame parity, sampled with the last beat.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_par`  out  1  frame parity over all bits of all beats, mode-adjusted.
- `out_lane_par`  out  LANES  per-lane parity across all beats, mode-adjusted.
- `out_beats`  out  CNT_W  number of accepted beats, saturating.
- `out_err`  out  1  `out_par != in_exp_par`.
- `out_ovf`  out  1  beat counter saturated during the frame.

## Operation
- Two-state FSM.
  - ACC: `in_ready=1`, `out_valid=0`.
  - DONE: `in_ready=0`, `out_valid=1`.
- A beat is accepted when `in_valid && in_ready`.
- Internal state:
  - `acc_lane[LANES-1:0]`: running XOR of each lane slice's reduction-XOR.
  - `cnt`: beat count.
  - `first`: set when no beat of the current frame has been accepted yet.
  - `mode_q`: captured parity mode.
- Accepted beat with `first=1`: capture `mode_q <= odd_mode` and clear `first`. Otherwise `odd_mode` is ignored.
- Accepted beat: `acc_lane[i] ^= ^lane_i(in_data)`.
  - If `cnt == 2^CNT_W-1`, `cnt` holds and sticky `ovf_q` sets.
  - Otherwise `cnt += 1`.
- Accepted beat with `in_last=1`:
  - Compute the final lane vector L = `acc_lane ^ lane_xor(in_data)`.
  - Register `out_lane_par = L ^ {LANES{mode}}`.
  - Register `out_par = ^L ^ mode`, where mode is `odd_mode` if this is also the first beat, else `mode_q`.
  - Register `out_err = out_par_next != in_exp_par`.
  - Register `out_beats` and `out_ovf` with their post-beat values.
  - Go to DONE.
- DONE: all outputs hold stable until `out_valid && out_ready`. Then clear accumulators, `cnt`, `ovf_q` and set `first=1`, and return to ACC.
- No new beat is accepted in the cycle the result is consumed; `in_ready` rises the following cycle.
- `in_data`, `in_last` and `in_exp_par` are don't-care when a beat is not accepted.

## Timing
- Reset (`reset=0`) values:
  - state ACC; `in_ready=1`; `out_valid=0`.
  - `out_par=0`, `out_lane_par=0`, `out_beats=0`, `out_err=0`, `out_ovf=0`.
  - accumulators 0; `first=1`.
- Reset assertion mid-frame or in DONE discards the frame with no output.
- Outputs are registered: the result is valid the cycle after the last beat is accepted (latency 1).
- Throughput: one beat per cycle within a frame, plus one DONE cycle minimum per frame (N-beat frame occupies at least N+1 cycles).
- Single-beat frames are legal (`in_last` on the first beat).
- `in_ready` and `out_valid` are always mutually exclusive and depend on state only, with no combinational path from inputs.
- `out_ready` held low: DONE persists indefinitely with outputs frozen.

## Test plan
- Single beat, WIDTH=32, LANES=4, even: `in_data=0x000000BC`, last=1, `in_exp_par=1` -> next cycle `out_valid=1`, `out_par=1`, `out_lane_par=4'b0001`, `out_beats=1`, `out_err=0`, `out_ovf=0`.
- Same beat with `odd_mode=1` and `in_exp_par=1` -> `out_par=0`, `out_lane_par=4'b1110`, `out_err=1`.
- Three beats, even, back-to-back: `0x000000FF`, `0x00000001`, then `0x80000000` with last=1 -> `out_lane_par=4'b1001`, `out_par=0`, `out_beats=3`. Also check that `odd_mode` toggled on beats 2–3 is ignored.
- Backpressure: hold `out_ready=0` for 5 cycles in DONE while driving `in_valid=1` -> `in_ready=0` throughout and outputs unchanged. Raise `out_ready` -> `out_valid=0` next cycle and `in_ready=1`; the next frame starts from cleared accumulators.
- Overflow: 300-beat frame of `0x00000001`, CNT_W=8 -> `out_beats=255`, `out_ovf=1`, `out_lane_par=4'b0000` (300 even), `out_par=0`.
- Reset mid-frame: assert `reset=0` asynchronously after 2 of 4 beats -> all outputs zero immediately. After release, a fresh single-beat frame `0x000000BC` yields `out_beats=1`, `out_par=1`.
